// File: rtl/uart_loader_pkg.sv
// uart_loader_pkg: shared widths, word/address types and loader FSM encoding.
package uart_loader_pkg;
  localparam int ADDR_WIDTH = 16;
  localparam int WORD_WIDTH = 16;
  typedef logic [WORD_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef enum logic [2:0] {S_ADDR, S_COUNT, S_DATA, S_WRITE, S_CSUM, S_DONE} state_t;
endpackage

// File: rtl/uart_loader_if.sv
// uart_loader_if: received-word stream, memory write port and CPU control of the loader.
interface uart_loader_if;
  import uart_loader_pkg::*;
  word_t in_word;
  logic  in_word_ready;
  addr_t mem_addr;
  word_t mem_data;
  logic  mem_wr_req;
  logic  mem_wr_ack;
  logic  cpu_hold;
  logic  load_done;
  logic  load_err;
  modport master (input in_word, in_word_ready, mem_wr_ack,
                  output mem_addr, mem_data, mem_wr_req, cpu_hold, load_done, load_err);
  modport slave  (output in_word, in_word_ready, mem_wr_ack,
                  input mem_addr, mem_data, mem_wr_req, cpu_hold, load_done, load_err);
endinterface

// File: rtl/uart_loader_pending_buf.sv
// loader_pending_buf: one-entry holding register for a word that arrives while a write is outstanding.
module loader_pending_buf
  import uart_loader_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  push_i,
  input  logic  pop_i,
  input  word_t data_i,
  output logic  full_o,
  output word_t data_o
);
  logic  full_q;
  word_t data_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (push_i) begin
      full_q <= 1'b1;
      data_q <= data_i;
    end else if (pop_i) begin
      full_q <= 1'b0;
    end
  end
  assign full_o = full_q;
  assign data_o = data_q;
endmodule

// File: rtl/uart_loader.sv
// uart_loader: parses address/count/data/checksum word stream into memory writes while holding the CPU.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  uart_loader_if.master bus_io
);
  state_t      state_q;
  addr_t       addr_q;
  word_t       data_q, sum_q, cnt_q;
  logic        req_q, hold_q, done_q, err_q, abort_q;
  logic [31:0] tmo_q;
  logic        full, stall, ack, ovr, push, pop, w_vld, timeout;
  word_t       pend, w;
  loader_pending_buf u_pend (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .pop_i  (pop),
    .data_i (bus_io.in_word),
    .full_o (full),
    .data_o (pend)
  );
  // In S_WRITE/S_DONE words are only buffered; elsewhere a buffered word is consumed first.
  always_comb begin
    stall   = state_q inside {S_WRITE, S_DONE};
    ack     = req_q && bus_io.mem_wr_ack;
    ovr     = stall && bus_io.in_word_ready && full && !abort_q;
    push    = bus_io.in_word_ready && !abort_q && (stall ? !full : full);
    pop     = stall ? ack && (abort_q || ovr) : full;
    w_vld   = !stall && (full || bus_io.in_word_ready);
    w       = full ? pend : bus_io.in_word;
    timeout = (state_q inside {S_COUNT, S_DATA, S_CSUM}) && !w_vld
              && tmo_q == 32'(TIMEOUT_CYCLES - 1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_ADDR;
      addr_q  <= '0;
      data_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
      tmo_q   <= '0;
    end else begin
      done_q  <= 1'b0;
      tmo_q   <= (w_vld || stall || state_q == S_ADDR) ? '0 : tmo_q + 32'd1;
      abort_q <= abort_q || ovr;
      if (ovr) err_q <= 1'b1;
      case (state_q)
        S_ADDR: if (w_vld) begin
          addr_q  <= w;
          err_q   <= 1'b0;
          hold_q  <= 1'b1;
          sum_q   <= '0;
          state_q <= S_COUNT;
        end
        S_COUNT: if (w_vld) begin
          cnt_q   <= w;
          state_q <= (w == '0) ? S_CSUM : S_DATA;
        end
        S_DATA: if (w_vld) begin
          data_q  <= w;
          sum_q   <= sum_q + w;
          state_q <= S_WRITE;
        end
        S_WRITE: if (!req_q) begin
          req_q <= 1'b1;
        end else if (ack) begin
          req_q   <= 1'b0;
          addr_q  <= addr_q + 1'b1;
          cnt_q   <= cnt_q - 1'b1;
          abort_q <= 1'b0;
          if (abort_q || ovr) begin
            hold_q  <= 1'b0;
            state_q <= S_ADDR;
          end else begin
            state_q <= (cnt_q == 16'd1) ? S_CSUM : S_DATA;
          end
        end
        S_CSUM: if (w_vld) begin
          if (w == sum_q) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            err_q   <= 1'b1;
            hold_q  <= 1'b0;
            state_q <= S_ADDR;
          end
        end
        S_DONE: begin
          hold_q  <= 1'b0;
          abort_q <= 1'b0;
          state_q <= S_ADDR;
        end
        default: state_q <= S_ADDR;
      endcase
      if (timeout) begin
        err_q   <= 1'b1;
        hold_q  <= 1'b0;
        state_q <= S_ADDR;
      end
    end
  end
  assign bus_io.mem_addr   = addr_q;
  assign bus_io.mem_data   = data_q;
  assign bus_io.mem_wr_req = req_q;
  assign bus_io.cpu_hold   = hold_q;
  assign bus_io.load_done  = done_q;
  assign bus_io.load_err   = err_q;
endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: randomized word streams checked against a stream-level model of the loader.
module tb_uart_loader;
  import uart_loader_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic resp_ack = 1'b0, spur_ack = 1'b0, ack_block = 1'b0;
  int   ack_dly_max = 0, dly_cnt = 0;
  int   checks = 0, errors = 0, done_cnt = 0;
  addr_t wr_a[$];
  word_t wr_d[$];
  uart_loader_if bus();
  uart_loader #(.TIMEOUT_CYCLES(16)) dut (.clk(clk), .rst(rst), .bus_io(bus));
  assign bus.mem_wr_ack = resp_ack | spur_ack;
  always #5 clk = ~clk;
  // Memory model: acks a seen request after a random delay and logs the accepted write.
  always @(posedge clk) begin
    #1;
    if (resp_ack) resp_ack = 1'b0;
    else if (bus.mem_wr_req && !ack_block) begin
      if (dly_cnt == 0) begin
        resp_ack = 1'b1;
        wr_a.push_back(bus.mem_addr);
        wr_d.push_back(bus.mem_data);
        dly_cnt = $urandom_range(0, ack_dly_max);
      end else dly_cnt--;
    end
  end
  always @(negedge clk) if (bus.load_done) done_cnt++;
  task automatic send_word(input word_t v, input int gap);
    @(posedge clk); #1;
    bus.in_word = v;
    bus.in_word_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_word_ready = 1'b0;
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
  endtask
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    wr_a.delete();
    wr_d.delete();
    done_cnt = 0;
  endtask
  task automatic wait_idle(input string name);
    int k = 0;
    while (bus.cpu_hold && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (bus.cpu_hold) begin errors++; $display("FAIL %s idle_timeout cpu_hold=%b want 0", name, bus.cpu_hold); end
    @(posedge clk); #1;
  endtask
  // Whole-load model: writes land at A+i (mod 2^16); done iff checksum equals the 16-bit data sum.
  task automatic run_stream(input string name, input word_t a, input word_t d[$], input word_t c);
    word_t sum = '0;
    bit exp_done;
    wr_a.delete();
    wr_d.delete();
    done_cnt = 0;
    foreach (d[i]) sum += d[i];
    exp_done = (sum == c);
    send_word(a, 3);
    checks++;
    if (bus.cpu_hold !== 1'b1) begin errors++; $display("FAIL %s hold_after_addr got %b want 1", name, bus.cpu_hold); end
    send_word(word_t'(d.size()), 3 + $urandom_range(0, 2));
    foreach (d[i]) send_word(d[i], 3 + $urandom_range(0, 2));
    send_word(c, 0);
    wait_idle(name);
    checks++;
    if (wr_a.size() != d.size()) begin errors++; $display("FAIL %s write_count got %0d want %0d", name, wr_a.size(), d.size()); end
    for (int i = 0; i < d.size() && i < wr_a.size(); i++) begin
      checks++;
      if (wr_a[i] !== addr_t'(a + addr_t'(i)) || wr_d[i] !== d[i]) begin
        errors++;
        $display("FAIL %s write%0d got %h:%h want %h:%h", name, i, wr_a[i], wr_d[i], addr_t'(a + addr_t'(i)), d[i]);
      end
    end
    checks++;
    if (done_cnt != int'(exp_done)) begin errors++; $display("FAIL %s done_pulses got %0d want %0d", name, done_cnt, exp_done); end
    checks++;
    if (bus.load_err !== !exp_done) begin errors++; $display("FAIL %s load_err got %b want %b", name, bus.load_err, !exp_done); end
    checks++;
    if (dut.state_q !== S_ADDR || bus.mem_wr_req !== 1'b0) begin errors++; $display("FAIL %s end_state got %0d req %b want S_ADDR req 0", name, dut.state_q, bus.mem_wr_req); end
  endtask
  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.mem_wr_req, bus.cpu_hold, bus.load_done, bus.load_err} !== 4'b0 || bus.mem_addr !== '0 || bus.mem_data !== '0) begin
      errors++;
      $display("FAIL reset outs got req%b hold%b done%b err%b addr%h data%h want all 0", bus.mem_wr_req, bus.cpu_hold, bus.load_done, bus.load_err, bus.mem_addr, bus.mem_data);
    end
    @(posedge clk); #1;
    spur_ack = 1'b1;
    @(posedge clk); #1;
    spur_ack = 1'b0;
    checks++;
    if (bus.mem_addr !== '0 || dut.state_q !== S_ADDR) begin errors++; $display("FAIL idle_ack addr got %h state %0d want 0000 S_ADDR", bus.mem_addr, dut.state_q); end
  endtask
  task automatic test_directed();
    run_stream("basic", 16'h0100, '{16'h1111, 16'h2222, 16'h3333}, 16'h6666);
    run_stream("wrap", 16'hFFFF, '{16'hAAAA, 16'h5555}, 16'hFFFF);
    run_stream("bad_csum", 16'h0100, '{16'h1111, 16'h2222, 16'h3333}, 16'h0000);
    checks++;
    if (bus.cpu_hold !== 1'b0) begin errors++; $display("FAIL bad_csum hold got %b want 0", bus.cpu_hold); end
    run_stream("zero_count", 16'h0500, '{}, 16'h0000);
  endtask
  task automatic test_latency();
    do_reset();
    send_word(16'h0200, 2);
    send_word(16'h0001, 2);
    send_word(16'h1234, 0);
    checks++;
    if (bus.mem_wr_req !== 1'b0) begin errors++; $display("FAIL latency_1 req got %b want 0", bus.mem_wr_req); end
    spur_ack = 1'b1;
    @(posedge clk); #1;
    spur_ack = 1'b0;
    checks++;
    if (bus.mem_wr_req !== 1'b1 || bus.mem_addr !== 16'h0200 || bus.mem_data !== 16'h1234) begin
      errors++;
      $display("FAIL latency_2 got req%b %h:%h want req1 0200:1234", bus.mem_wr_req, bus.mem_addr, bus.mem_data);
    end
    send_word(16'h1234, 0);
    wait_idle("latency");
    checks++;
    if (done_cnt != 1 || wr_a.size() != 1) begin errors++; $display("FAIL latency_done got done%0d writes%0d want 1 1", done_cnt, wr_a.size()); end
  endtask
  task automatic test_overrun();
    do_reset();
    ack_block = 1'b1;
    send_word(16'h0040, 3);
    send_word(16'h0004, 3);
    send_word(16'hA001, 3);
    send_word(16'hA002, 3);
    send_word(16'hA003, 0);
    checks++;
    if (bus.load_err !== 1'b1) begin errors++; $display("FAIL overrun_err got %b want 1", bus.load_err); end
    repeat (28) @(posedge clk);
    #1;
    checks++;
    if (bus.cpu_hold !== 1'b1 || bus.mem_wr_req !== 1'b1) begin errors++; $display("FAIL overrun_wait got hold%b req%b want 1 1", bus.cpu_hold, bus.mem_wr_req); end
    ack_block = 1'b0;
    wait_idle("overrun");
    checks++;
    if (wr_a.size() != 1 || wr_a[0] !== 16'h0040 || wr_d[0] !== 16'hA001) begin errors++; $display("FAIL overrun_writes got %0d entries want 1 at 0040:a001", wr_a.size()); end
    checks++;
    if (bus.load_err !== 1'b1 || done_cnt != 0 || dut.state_q !== S_ADDR || bus.mem_addr !== 16'h0041) begin
      errors++;
      $display("FAIL overrun_end got err%b done%0d state%0d addr%h want 1 0 S_ADDR 0041", bus.load_err, done_cnt, dut.state_q, bus.mem_addr);
    end
  endtask
  task automatic test_timeout();
    do_reset();
    send_word(16'h0010, 2);
    send_word(16'h0002, 0);
    repeat (15) @(posedge clk);
    #1;
    checks++;
    if (bus.load_err !== 1'b0 || bus.cpu_hold !== 1'b1) begin errors++; $display("FAIL timeout_early got err%b hold%b want 0 1", bus.load_err, bus.cpu_hold); end
    @(posedge clk); #1;
    checks++;
    if (bus.load_err !== 1'b1 || bus.cpu_hold !== 1'b0 || dut.state_q !== S_ADDR) begin
      errors++;
      $display("FAIL timeout_fire got err%b hold%b state%0d want 1 0 S_ADDR", bus.load_err, bus.cpu_hold, dut.state_q);
    end
  endtask
  task automatic test_rst_write();
    do_reset();
    ack_block = 1'b1;
    send_word(16'h0300, 2);
    send_word(16'h0001, 2);
    send_word(16'h5555, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.mem_wr_req !== 1'b0 || bus.cpu_hold !== 1'b0 || bus.load_done !== 1'b0 || dut.state_q !== S_ADDR) begin
      errors++;
      $display("FAIL rst_mid_write got req%b hold%b done%b state%0d want 0 0 0 S_ADDR", bus.mem_wr_req, bus.cpu_hold, bus.load_done, dut.state_q);
    end
    rst = 1'b0;
    ack_block = 1'b0;
  endtask
  task automatic test_random();
    ack_dly_max = 1;
    for (int t = 0; t < 8; t++) begin
      word_t d[$];
      word_t s = '0;
      int n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++) begin
        d.push_back(word_t'($urandom));
        s += d[i];
      end
      if ($urandom_range(0, 2) == 0) s = s + word_t'($urandom_range(1, 500));
      run_stream($sformatf("rand%0d", t), word_t'($urandom_range(16'hFFF8, 16'hFFFF) - (t % 2) * 16'h7000), d, s);
    end
    ack_dly_max = 0;
  endtask
  initial begin
    bus.in_word = '0;
    bus.in_word_ready = 1'b0;
    test_reset();
    test_directed();
    test_latency();
    test_overrun();
    test_timeout();
    test_rst_write();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
